// File: rtl/mul_normaliser_seq_if.sv
// Handshake bundle for the sequential product normaliser.
// Operand side: in_valid/in_ready with in_e (biased exponent) and in_m (raw product).
// Result side: out_valid/out_ready with out_e, out_m and the zero/underflow/overflow flags.
// master: the environment that supplies operands and consumes results.
// slave : the normaliser itself.
interface mul_normaliser_seq_if #(
    parameter int EW = 8,
    parameter int MW = 48
);
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] in_e;
    logic [MW-1:0] in_m;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] out_e;
    logic [MW-1:0] out_m;
    logic          out_zero;
    logic          out_underflow;
    logic          out_overflow;

    modport master (
        output in_valid, in_e, in_m, out_ready,
        input  in_ready, out_valid, out_e, out_m, out_zero, out_underflow, out_overflow
    );

    modport slave (
        input  in_valid, in_e, in_m, out_ready,
        output in_ready, out_valid, out_e, out_m, out_zero, out_underflow, out_overflow
    );
endinterface

// File: rtl/mul_normaliser_seq.sv
// Sequential normaliser for a floating-point multiplier product.
// Takes an unnormalised exponent/mantissa pair and shifts the mantissa until
// its hidden bit sits at position MW-2. Each cycle does at most one right shift
// by one position or one left shift by up to STEP positions, and the exponent
// tracks every shift. It reports zero, underflow (exponent would drop below 1)
// and overflow (exponent reaches all-ones).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of mul_normaliser_seq_if (operand and result handshakes)
module mul_normaliser_seq #(
    parameter int EW   = 8,
    parameter int MW   = 48,
    parameter int STEP = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mul_normaliser_seq_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    // One guard bit above the exponent, so that +1 / -s never wraps unnoticed.
    localparam logic [EW:0] EMAX = {1'b0, {EW{1'b1}}};
    localparam logic [EW:0] ONE  = {{EW{1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [EW:0]   e_q, e_d;
    logic [MW-1:0] m_q, m_d;
    logic          zero_q, zero_d;
    logic          unf_q, unf_d;
    logic          ovf_q, ovf_d;

    int            lz;     // leading zeros counted downward from bit MW-2
    int            shamt;  // left-shift amount for this NORM cycle

    // State and working registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            e_q     <= '0;
            m_q     <= '0;
            zero_q  <= 1'b0;
            unf_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            m_q     <= m_d;
            zero_q  <= zero_d;
            unf_q   <= unf_d;
            ovf_q   <= ovf_d;
        end
    end

    // Leading-zero count and the bounded shift amount. The ascending scan lets
    // the highest set bit win. The exponent bound keeps e >= 1 after a shift.
    always_comb begin
        lz = MW - 1;
        for (int i = 0; i <= MW - 2; i++) begin
            if (m_q[i]) lz = MW - 2 - i;
        end
        if (e_q <= ONE) begin
            shamt = 0;
        end else begin
            shamt = lz;
            if (shamt > STEP) shamt = STEP;
            if (shamt > int'(e_q) - 1) shamt = int'(e_q) - 1;
        end
    end

    // Next-state and datapath update; exactly one rule fires per NORM cycle.
    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_d = state_q;
        e_d     = e_q;
        m_d     = m_q;
        zero_d  = zero_q;
        unf_d   = unf_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    e_d     = {1'b0, bus.in_e};
                    m_d     = bus.in_m;
                    zero_d  = 1'b0;
                    unf_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (m_q == '0) begin
                    zero_d  = 1'b1;
                    e_d     = '0;
                    state_d = DONE;
                end else if (e_q >= EMAX || (m_q[MW-1] && (e_q + ONE) >= EMAX)) begin
                    ovf_d   = 1'b1;
                    e_d     = EMAX;
                    m_d     = '0;
                    state_d = DONE;
                end else if (m_q[MW-1]) begin
                    m_d = m_q >> 1;
                    e_d = e_q + ONE;
                end else if (m_q[MW-2]) begin
                    state_d = DONE;
                end else if (shamt == 0) begin
                    unf_d   = 1'b1;
                    e_d     = '0;
                    state_d = DONE;
                end else begin
                    m_d = m_q << shamt;
                    e_d = e_q - (EW+1)'(shamt);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on registered state only.
    always_comb begin
        bus.in_ready      = (state_q == IDLE);
        bus.out_valid     = (state_q == DONE);
        bus.out_e         = e_q[EW-1:0];
        bus.out_m         = m_q;
        bus.out_zero      = zero_q;
        bus.out_underflow = unf_q;
        bus.out_overflow  = ovf_q;
    end

endmodule

// File: tb/tb_mul_normaliser_seq.sv
// Scoreboard bench for mul_normaliser_seq (EW=8, MW=48, STEP=4).
// The driver pushes hand-computed results into a queue when it issues an
// operand. The monitor pops one entry on each new out_valid and compares it.
module tb_mul_normaliser_seq;

    localparam int EW = 8;
    localparam int MW = 48;

    typedef struct {
        logic [EW-1:0] e;
        logic [MW-1:0] m;
        logic          z;
        logic          u;
        logic          o;
        int            lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   accept_cyc;
    int   n_pass;
    int   n_total;
    exp_t sb[$];

    mul_normaliser_seq_if #(.EW(EW), .MW(MW)) bus ();

    mul_normaliser_seq #(.EW(EW), .MW(MW), .STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [MW-1:0] bit_m(input int pos);
        logic [MW-1:0] one;
        one = 1;
        return one << pos;
    endfunction

    // Presents an operand and waits for the accept edge; optionally queues the expected result.
    task automatic issue(input logic [EW-1:0] e, input logic [MW-1:0] m, input bit push,
                         input exp_t x);
        int budget;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_e     = e;
        bus.in_m     = m;
        budget = 0;
        while (!bus.in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) check("accept_timeout", 0, 1);
        if (push) sb.push_back(x);
        @(posedge clk);
        #1;
        accept_cyc   = cyc;
        bus.in_valid = 1'b0;
    endtask

    // Waits until every queued result has been handed off and the block is idle again.
    task automatic wait_done();
        int budget;
        budget = 0;
        while ((sb.size() != 0 || bus.out_valid) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0 || bus.out_valid) check("completion_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic run(input logic [EW-1:0] e, input logic [MW-1:0] m, input logic [EW-1:0] xe,
                       input logic [MW-1:0] xm, input logic z, input logic u, input logic o,
                       input int lat);
        exp_t x;
        x.e = xe; x.m = xm; x.z = z; x.u = u; x.o = o; x.lat = lat;
        issue(e, m, 1'b1, x);
        wait_done();
    endtask

    // Monitor: one scoreboard pop per out_valid assertion.
    initial begin
        bit   seen;
        exp_t x;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (bus.out_valid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    x = sb.pop_front();
                    check("out_e", 64'(bus.out_e), 64'(x.e));
                    check("out_m", 64'(bus.out_m), 64'(x.m));
                    check("out_zero", 64'(bus.out_zero), 64'(x.z));
                    check("out_underflow", 64'(bus.out_underflow), 64'(x.u));
                    check("out_overflow", 64'(bus.out_overflow), 64'(x.o));
                    check("latency", 64'(cyc - accept_cyc), 64'(x.lat));
                end
            end else if (!bus.out_valid) begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 1);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 0);
        check({tag, "_out_e"}, 64'(bus.out_e), 0);
        check({tag, "_out_m"}, 64'(bus.out_m), 0);
        check({tag, "_flags"}, 64'({bus.out_zero, bus.out_underflow, bus.out_overflow}), 0);
    endtask

    initial begin
        exp_t x;
        cyc           = 0;
        accept_cyc    = 0;
        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_e      = '0;
        bus.in_m      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // e, m, expected e, expected m, zero, underflow, overflow, latency
        run(8'd100, bit_m(41), 8'd95, bit_m(46), 1'b0, 1'b0, 1'b0, 3);
        run(8'd127, bit_m(47) | bit_m(0), 8'd128, bit_m(46), 1'b0, 1'b0, 1'b0, 2);
        run(8'd3, bit_m(40), 8'd0, bit_m(42), 1'b0, 1'b1, 1'b0, 2);
        run(8'd50, '0, 8'd0, '0, 1'b1, 1'b0, 1'b0, 1);
        run(8'd254, bit_m(47), 8'd255, '0, 1'b0, 1'b0, 1'b1, 1);
        run(8'd255, bit_m(46), 8'd255, '0, 1'b0, 1'b0, 1'b1, 1);
        run(8'd10, bit_m(46) | bit_m(3), 8'd10, bit_m(46) | bit_m(3), 1'b0, 1'b0, 1'b0, 1);
        run(8'd1, bit_m(45), 8'd0, bit_m(45), 1'b0, 1'b1, 1'b0, 1);
        run(8'd200, bit_m(0), 8'd154, bit_m(46), 1'b0, 1'b0, 1'b0, 13);

        // Result held in DONE with out_ready low; in_valid pulses must be ignored.
        bus.out_ready = 1'b0;
        x.e = 8'd95; x.m = bit_m(46); x.z = 1'b0; x.u = 1'b0; x.o = 1'b0; x.lat = 3;
        issue(8'd100, bit_m(41), 1'b1, x);
        begin
            int budget;
            budget = 0;
            while (!bus.out_valid && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (!bus.out_valid) check("hold_reach_done", 0, 1);
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.in_e     = 8'd7;
            bus.in_m     = bit_m(2);
            @(negedge clk);
            check("hold_out_valid", 64'(bus.out_valid), 1);
            check("hold_in_ready", 64'(bus.in_ready), 0);
            check("hold_out_e", 64'(bus.out_e), 95);
            check("hold_out_m", 64'(bus.out_m), 64'(bit_m(46)));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("handoff_out_valid", 64'(bus.out_valid), 0);
        check("handoff_in_ready", 64'(bus.in_ready), 1);
        wait_done();

        // Reset one cycle into an operation: the operation is discarded.
        issue(8'd60, bit_m(10), 1'b0, x);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("abort_no_valid", 64'(bus.out_valid), 0);
        end
        run(8'd100, bit_m(41), 8'd95, bit_m(46), 1'b0, 1'b0, 1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul_normaliser_seq.md
MUL_NORMALISER_SEQ -- requirements
Module: mul_normaliser_seq

Interface
REQ-001 Parameter EW, default 8, exponent width (biased, unsigned).
REQ-002 Parameter MW, default 48, product mantissa width; hidden-bit target position is MW-2.
REQ-003 Parameter STEP, default 4, maximum left-shift positions per cycle (1..MW-2).
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port in_valid  input  1  operand present.
REQ-007 Port in_ready  output  1  block can accept an operand.
REQ-008 Port in_e  input  EW  unnormalised exponent.
REQ-009 Port in_m  input  MW  raw mantissa product.
REQ-010 Port out_valid  output  1  result present.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port out_e  output  EW  normalised exponent.
REQ-013 Port out_m  output  MW  normalised mantissa.
REQ-014 Port out_zero, out_underflow, out_overflow  output  1 each  result flags.

Function
REQ-015 The FSM SHALL have states IDLE, NORM, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 An operand is accepted on a rising edge with in_valid & in_ready: in_e/in_m are captured into working registers e/m, flags are cleared, and the state goes to NORM.
REQ-017 Exponent arithmetic SHALL use an EW+1-bit internal register, so increments and decrements never wrap silently.
REQ-018 Each NORM cycle SHALL evaluate exactly one rule, highest priority first:
- m==0: out_zero=1, e=0, go to DONE.
- e == 2^EW-1, or m[MW-1]=1 with e+1 >= 2^EW-1: out_overflow=1, e=2^EW-1, m=0, go to DONE.
- m[MW-1]=1: m = m>>1 (LSB truncated), e = e+1, stay in NORM.
- m[MW-2]=1: go to DONE, no change.
- Otherwise: lz = leading zeros counted from bit MW-2; s = min(lz, STEP, e-1). If s==0 (e<=1): out_underflow=1, e=0, m unchanged, go to DONE. Else m = m<<s, e = e-s, stay in NORM.
REQ-019 Latency from the accept edge to out_valid high SHALL be 1 + number of shifting NORM cycles. With STEP=4 the maximum is 1 + ceil((MW-2)/STEP) cycles.
REQ-020 In DONE, out_e/out_m/flags SHALL hold stable until the edge where out_ready=1; that edge returns the FSM to IDLE.
REQ-021 The block SHALL NOT accept an operand in the same cycle as a result handoff; the next accept occurs no earlier than the following cycle (in_ready is low in DONE).
REQ-022 in_valid asserted while the FSM is in NORM or DONE SHALL be ignored, and the captured operand is unaffected.
REQ-023 out_e SHALL equal the low EW bits of the internal exponent; out_m SHALL equal m.
REQ-024 With STEP=1 and MW=48, shift behaviour SHALL be bit-equivalent to one-position-per-cycle normalisation.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, out_valid=0, in_ready=1 once released, out_e=0, out_m=0, and out_zero, out_underflow, out_overflow all 0.
REQ-026 rst_n asserted during NORM or DONE SHALL discard the operation; no out_valid pulse follows the release of rst_n.

Verification (EW=8, MW=48, STEP=4)
REQ-027 in_e=100, in_m=1<<41, out_ready=1: out_valid 3 cycles after accept; out_e=95, out_m=1<<46, all flags 0.
REQ-028 in_e=127, in_m=(1<<47)|1: out_valid 2 cycles after accept; out_e=128, out_m=1<<46, flags 0.
REQ-029 in_e=3, in_m=1<<40: out_valid 2 cycles after accept; out_underflow=1, out_e=0, out_m=1<<42. Also in_e=50, in_m=0: out_valid after 1 cycle; out_zero=1, out_e=0, out_m=0.
REQ-030 in_e=254, in_m=1<<47: out_overflow=1, out_e=255, out_m=0.
REQ-031 Hold out_ready=0 for 5 cycles in DONE: outputs stay stable, in_ready stays 0, and in_valid pulses are ignored. Raising out_ready gives one handoff, and in_ready is 1 on the next cycle.
REQ-032 Assert rst_n=0 one cycle after accepting in_m=1<<10: out_valid stays 0 and all outputs are 0. After release, a fresh operand is accepted and completes per REQ-019.
